// File: rtl/reg_file_mp_if.sv
// reg_file_mp_if: bus bundle for the multi-port register file.
//   master modport (core / testbench side) drives addresses, write data,
//   scoreboard set and clear request; slave modport (register file) drives
//   read data, busy bits and clr_busy.
// Signals:
//   r_addr  [NR*W]  read addresses, port i = r_addr[i*W +: W]
//   r_data  [NR*B]  read data, port i = r_data[i*B +: B]
//   r_busy  [NR]    scoreboard bit of each read address
//   wr_en   [2]     write enable per write port
//   w_addr  [2*W]   write addresses, port j = w_addr[j*W +: W]
//   w_data  [2*B]   write data, port j = w_data[j*B +: B]
//   sb_set          mark sb_addr busy
//   sb_addr [W]     scoreboard set address
//   clr_req         start the clear sweep
//   clr_busy        high while the sweep runs
interface reg_file_mp_if #(
  parameter int W  = 5,
  parameter int B  = 32,
  parameter int NR = 2
);
  logic [NR*W-1:0] r_addr;
  logic [NR*B-1:0] r_data;
  logic [NR-1:0]   r_busy;
  logic [1:0]      wr_en;
  logic [2*W-1:0]  w_addr;
  logic [2*B-1:0]  w_data;
  logic            sb_set;
  logic [W-1:0]    sb_addr;
  logic            clr_req;
  logic            clr_busy;

  modport master (
    output r_addr, wr_en, w_addr, w_data, sb_set, sb_addr, clr_req,
    input  r_data, r_busy, clr_busy
  );

  modport slave (
    input  r_addr, wr_en, w_addr, w_data, sb_set, sb_addr, clr_req,
    output r_data, r_busy, clr_busy
  );
endinterface

// File: rtl/reg_file_mp.sv
// reg_file_mp: parametrised multi-port integer register file with a
// per-register busy scoreboard and a sequenced clear engine.
//   NR combinational read ports, 2 synchronous write ports (port 1 wins on
//   same-address collision), optional hardwired x0 (ZERO_REG).
//   The clear engine zeroes one entry (data and busy) per cycle for 2**W
//   cycles; writes and scoreboard sets are dropped while it runs.
// Ports:
//   clk    clock, all state updates on posedge
//   reset  asynchronous, active-high reset
//   bus    reg_file_mp_if.slave (read/write/scoreboard/clear signals)
// Optional feature macro: REG_FILE_BYPASS_EN
//   defined   -> write data is forwarded to same-cycle reads (not during sweep)
//   undefined -> reads see committed state only
module reg_file_mp #(
  parameter int W        = 5,
  parameter int B        = 32,
  parameter int NR       = 2,
  parameter int ZERO_REG = 1
) (
  input  logic            clk,
  input  logic            reset,
  reg_file_mp_if.slave    bus
);
  localparam int DEPTH = 2 ** W;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SWEEP = 1'b1;

  logic [0:0]     state;
  logic [W-1:0]   cnt;
  logic [B-1:0]   mem [DEPTH];
  logic [DEPTH-1:0] busy;

  logic [W-1:0]   wa0, wa1, sba;
  logic [B-1:0]   wd0, wd1;
  logic           we0, we1, set_ok;
  logic [NR*B-1:0] rd;
  logic [NR-1:0]   rb;
  logic [W-1:0]    ra;

  // True for the hardwired zero register, which ignores writes and sets.
  function automatic logic is_zero(input logic [W-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  assign wa0    = bus.w_addr[0 +: W];
  assign wa1    = bus.w_addr[W +: W];
  assign wd0    = bus.w_data[0 +: B];
  assign wd1    = bus.w_data[B +: B];
  assign sba    = bus.sb_addr;
  assign we0    = bus.wr_en[0] && !is_zero(wa0);
  assign we1    = bus.wr_en[1] && !is_zero(wa1);
  assign set_ok = bus.sb_set && !is_zero(sba);

  // Array, scoreboard and clear engine. Port 1 is assigned after port 0 so
  // it wins a same-address collision; the scoreboard set comes after the
  // writeback clears so a simultaneous set wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      busy  <= '0;
      for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (we0) mem[wa0] <= wd0;
          if (we1) mem[wa1] <= wd1;
          if (we0) busy[wa0] <= 1'b0;
          if (we1) busy[wa1] <= 1'b0;
          if (set_ok) busy[sba] <= 1'b1;
          if (bus.clr_req) begin
            state <= ST_SWEEP;
            cnt   <= '0;
          end
        end
        ST_SWEEP: begin
          mem[cnt]  <= '0;
          busy[cnt] <= 1'b0;
          cnt       <= cnt + 1'b1;
          if (cnt == {W{1'b1}}) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Combinational read ports. Forwarding, when built in, is suppressed in
  // SWEEP because the write it would forward is being dropped.
  always_comb begin
    rd = '0;
    rb = '0;
    ra = '0;
    for (int i = 0; i < NR; i++) begin
      ra = bus.r_addr[i*W +: W];
      rd[i*B +: B] = mem[ra];
      rb[i]        = busy[ra];
`ifdef REG_FILE_BYPASS_EN
      if (state == ST_IDLE) begin
        if (we0 && (wa0 == ra)) begin
          rd[i*B +: B] = wd0;
          rb[i]        = set_ok && (sba == ra);
        end
        if (we1 && (wa1 == ra)) begin
          rd[i*B +: B] = wd1;
          rb[i]        = set_ok && (sba == ra);
        end
      end
`endif
      if (is_zero(ra)) begin
        rd[i*B +: B] = '0;
        rb[i]        = 1'b0;
      end
    end
  end

  assign bus.r_data   = rd;
  assign bus.r_busy   = rb;
  assign bus.clr_busy = (state == ST_SWEEP);
endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp: scoreboard bench for reg_file_mp (W=5, B=32, NR=2,
// ZERO_REG=1). Stimulus pushes expected outputs into a queue; a monitor
// pops and compares them on the falling edge of the same cycle.
module tb_reg_file_mp;
  localparam int W = 5;
  localparam int B = 32;
  localparam int NR = 2;

  localparam int K_DATA = 0;
  localparam int K_BUSY = 1;
  localparam int K_CLR  = 2;

  typedef struct {
    int          kind;
    int          port;
    logic [31:0] value;
    string       name;
  } exp_t;

  logic clk;
  logic reset;
  exp_t q[$];
  int   checks;
  int   errors;

  reg_file_mp_if #(.W(W), .B(B), .NR(NR)) bus ();

  reg_file_mp #(.W(W), .B(B), .NR(NR), .ZERO_REG(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: every falling edge, compare everything queued for this cycle.
  always @(negedge clk) begin
    exp_t e;
    logic [31:0] got;
    while (q.size() > 0) begin
      e = q.pop_front();
      case (e.kind)
        K_DATA:  got = bus.r_data[e.port*B +: B];
        K_BUSY:  got = {31'd0, bus.r_busy[e.port]};
        default: got = {31'd0, bus.clr_busy};
      endcase
      checks++;
      if (got !== e.value) begin
        errors++;
        $display("[TB] FAIL %s: got %0h expected %0h", e.name, got, e.value);
      end
    end
  end

  task automatic expect_out(input int kind, input int port,
                            input logic [31:0] value, input string name);
    exp_t e;
    e.kind = kind; e.port = port; e.value = value; e.name = name;
    q.push_back(e);
  endtask

  // Advance one cycle and return the one-shot controls to idle.
  task automatic next_cycle();
    @(posedge clk);
    #1;
    bus.wr_en   = 2'b00;
    bus.sb_set  = 1'b0;
    bus.clr_req = 1'b0;
  endtask

  task automatic set_read(input logic [W-1:0] a0, input logic [W-1:0] a1);
    bus.r_addr = {a1, a0};
  endtask

  task automatic apply_stimulus(input logic [1:0] en,
                                input logic [W-1:0] a0, input logic [31:0] d0,
                                input logic [W-1:0] a1, input logic [31:0] d1);
    bus.wr_en  = en;
    bus.w_addr = {a1, a0};
    bus.w_data = {d1, d0};
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    bus.r_addr = '0; bus.wr_en = '0; bus.w_addr = '0; bus.w_data = '0;
    bus.sb_set = 1'b0; bus.sb_addr = '0; bus.clr_req = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    set_read(5'd0, 5'd1);
    expect_out(K_DATA, 0, 32'd0, "reset_rd0");
    expect_out(K_DATA, 1, 32'd0, "reset_rd1");
    expect_out(K_BUSY, 0, 32'd0, "reset_busy0");
    expect_out(K_CLR,  0, 32'd0, "reset_clr_busy");

    // Test 1: write to x0 discarded, write to x1 kept
    next_cycle();
    apply_stimulus(2'b01, 5'd0, 32'd10, 5'd0, 32'd0);
    expect_out(K_DATA, 0, 32'd0, "x0_write_cycle");
    next_cycle();
    apply_stimulus(2'b01, 5'd1, 32'd15, 5'd0, 32'd0);
`ifdef REG_FILE_BYPASS_EN
    expect_out(K_DATA, 1, 32'd15, "x1_bypass");
`else
    expect_out(K_DATA, 1, 32'd0, "x1_old");
`endif
    next_cycle();
    expect_out(K_DATA, 0, 32'd0, "x0_reads_zero");
    expect_out(K_DATA, 1, 32'd15, "x1_reads_15");

    // Test 2: both ports to address 20, port 1 wins
    next_cycle();
    apply_stimulus(2'b11, 5'd20, 32'd100, 5'd20, 32'd200);
    set_read(5'd20, 5'd20);
`ifdef REG_FILE_BYPASS_EN
    expect_out(K_DATA, 0, 32'd200, "dual_write_bypass");
`else
    expect_out(K_DATA, 0, 32'd0, "dual_write_old");
`endif
    next_cycle();
    expect_out(K_DATA, 0, 32'd200, "dual_write_port1_wins");
    expect_out(K_DATA, 1, 32'd200, "dual_write_port1_wins_rd1");

    // Test 3: scoreboard set, set-wins conflict, writeback clear
    next_cycle();
    bus.sb_set = 1'b1; bus.sb_addr = 5'd5;
    set_read(5'd5, 5'd0);
    expect_out(K_BUSY, 0, 32'd0, "sb_before_set");
    next_cycle();
    bus.sb_set = 1'b1; bus.sb_addr = 5'd5;
    apply_stimulus(2'b01, 5'd5, 32'd55, 5'd0, 32'd0);
    expect_out(K_BUSY, 0, 32'd1, "sb_after_set");
    next_cycle();
    apply_stimulus(2'b01, 5'd5, 32'd66, 5'd0, 32'd0);
`ifdef REG_FILE_BYPASS_EN
    expect_out(K_BUSY, 0, 32'd0, "sb_bypass_clear");
    expect_out(K_DATA, 0, 32'd66, "sb_bypass_data");
`else
    expect_out(K_BUSY, 0, 32'd1, "sb_set_wins");
    expect_out(K_DATA, 0, 32'd55, "sb_conflict_data");
`endif
    next_cycle();
    expect_out(K_BUSY, 0, 32'd0, "sb_cleared");
    expect_out(K_DATA, 0, 32'd66, "sb_clear_data");
    // Setting x0 busy is ignored
    bus.sb_set = 1'b1; bus.sb_addr = 5'd0;
    next_cycle();
    expect_out(K_BUSY, 1, 32'd0, "sb_x0_ignored");

    // Test 4: fill 1..31 with their index, mark 12 busy, then sweep
    for (int j = 1; j <= 31; j += 2) begin
      next_cycle();
      if (j + 1 <= 31)
        apply_stimulus(2'b11, 5'(j), 32'(j), 5'(j + 1), 32'(j + 1));
      else
        apply_stimulus(2'b01, 5'(j), 32'(j), 5'd0, 32'd0);
    end
    next_cycle();
    bus.sb_set = 1'b1; bus.sb_addr = 5'd12;
    set_read(5'd7, 5'd31);
    expect_out(K_DATA, 0, 32'd7, "fill_7");
    expect_out(K_DATA, 1, 32'd31, "fill_31");
    next_cycle();
    set_read(5'd12, 5'd0);
    expect_out(K_BUSY, 0, 32'd1, "busy12_before_sweep");
    bus.clr_req = 1'b1;
    expect_out(K_CLR, 0, 32'd0, "clr_busy_req_cycle");
    for (int k = 0; k < 32; k++) begin
      next_cycle();
      expect_out(K_CLR, 0, 32'd1, $sformatf("clr_busy_k%0d", k));
      if (k == 10) begin
        apply_stimulus(2'b01, 5'd7, 32'h77, 5'd0, 32'd0);
        bus.sb_set = 1'b1; bus.sb_addr = 5'd9;
        bus.clr_req = 1'b1;
        set_read(5'd20, 5'd7);
        expect_out(K_DATA, 0, 32'd20, "sweep_live_read20");
        expect_out(K_DATA, 1, 32'd0, "sweep_no_forward7");
      end
    end
    next_cycle();
    expect_out(K_CLR, 0, 32'd0, "clr_busy_done");
    for (int a = 0; a < 32; a += 2) begin
      next_cycle();
      set_read(5'(a), 5'(a + 1));
      expect_out(K_DATA, 0, 32'd0, $sformatf("post_sweep_%0d", a));
      expect_out(K_DATA, 1, 32'd0, $sformatf("post_sweep_%0d", a + 1));
    end
    next_cycle();
    set_read(5'd9, 5'd12);
    expect_out(K_BUSY, 0, 32'd0, "busy9_set_dropped");
    expect_out(K_BUSY, 1, 32'd0, "busy12_swept");
    expect_out(K_CLR,  0, 32'd0, "no_restart");

    // Test 5: reset asserted mid-sweep
    next_cycle();
    apply_stimulus(2'b01, 5'd25, 32'd250, 5'd0, 32'd0);
    next_cycle();
    set_read(5'd25, 5'd3);
    expect_out(K_DATA, 0, 32'd250, "pre_reset_25");
    bus.clr_req = 1'b1;
    for (int k = 0; k <= 10; k++) next_cycle();
    reset = 1'b1;
    #1;
    expect_out(K_CLR,  0, 32'd0, "reset_mid_clr_busy");
    expect_out(K_DATA, 0, 32'd0, "reset_mid_25");
    expect_out(K_DATA, 1, 32'd0, "reset_mid_3");
    next_cycle();
    reset = 1'b0;
    expect_out(K_CLR, 0, 32'd0, "after_reset_idle");
    bus.clr_req = 1'b1;
    next_cycle();
    expect_out(K_CLR, 0, 32'd1, "restart_after_reset");
    repeat (31) next_cycle();
    next_cycle();
    expect_out(K_CLR, 0, 32'd0, "restart_done");

    // Test 6: forwarding (or not) of a write to the address being read
    next_cycle();
    apply_stimulus(2'b01, 5'd3, 32'hDEAD_BEEF, 5'd0, 32'd0);
    set_read(5'd3, 5'd0);
`ifdef REG_FILE_BYPASS_EN
    expect_out(K_DATA, 0, 32'hDEAD_BEEF, "bypass_same_cycle");
`else
    expect_out(K_DATA, 0, 32'd0, "no_bypass_old");
`endif
    next_cycle();
    expect_out(K_DATA, 0, 32'hDEAD_BEEF, "write3_committed");

    next_cycle();
    next_cycle();
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard_drain: got %0d expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
